// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned MAX_NREQ   = 8;
   localparam int unsigned OWNER_W    = $clog2(MAX_NREQ);

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] adrs;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_cmd_t;

   // Owner field is sized for the largest supported requester count.
   typedef struct packed {
      logic               valid;
      logic [OWNER_W-1:0] owner;
   } arb_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_picker #(
   parameter  int unsigned NREQ  = 4,
   localparam int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_pos;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_sum = '0;
      w_pos = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // Position (ptr + k) mod NREQ without a divider.
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NREQ))
            w_sum = w_sum - (IDX_W+1)'(NREQ);
         w_pos = w_sum[IDX_W-1:0];
         if (!o_any && i_req[w_pos]) begin
            o_any        = 1'b1;
            o_gnt[w_pos] = 1'b1;
            o_idx        = w_pos;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory command port among NREQ requesters,
// with a 2-deep tag pipeline routing read data back to its owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_adrs,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     mem_w_en,
   output logic [ADDR_W-1:0]        mem_w_adrs,
   output logic [DATA_W-1:0]        mem_data_in,
   output logic                     mem_r_en,
   output logic [ADDR_W-1:0]        mem_r_adrs,
   input  logic [DATA_W-1:0]        mem_data_out,
   input  logic                     mem_r_valid,
   output logic                     err_tag
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  w_ptr_next;
   logic [NREQ-1:0]   w_gnt_raw;
   logic              w_any;
   logic              w_accept;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_adrs;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [NREQ-1:0]   w_owner_hot;
   logic              w_rsp_ok;
   logic              w_err_set;
   arb_tag_t          r_tag1;
   arb_tag_t          r_tag2;
   logic              r_rst_d;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt_raw),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign gnt         = reset ? '0 : w_gnt_raw;
   assign w_accept    = w_any & ~reset;
   assign w_sel_we    = req_we[w_idx];
   assign w_sel_adrs  = req_adrs[w_idx*ADDR_W +: ADDR_W];
   assign w_sel_wdata = req_wdata[w_idx*DATA_W +: DATA_W];
   assign w_ptr_next  = (w_idx == IDX_W'(NREQ-1)) ? '0 : w_idx + 1'b1;

   always_comb begin
      w_owner_hot = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         w_owner_hot[i] = (r_tag2.owner == OWNER_W'(i));
   end

   // A read issued in the reset cycle still comes back one cycle later; that
   // straggler is dropped silently instead of flagged as an orphan.
   assign w_rsp_ok  = r_tag2.valid & mem_r_valid;
   assign w_err_set = (mem_r_valid & ~r_tag2.valid & ~r_rst_d) |
                      (r_tag2.valid & ~mem_r_valid);

   always_ff @(posedge clk)
      r_rst_d <= reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= '0;
         mem_w_en    <= 1'b0;
         mem_r_en    <= 1'b0;
         mem_w_adrs  <= '0;
         mem_r_adrs  <= '0;
         mem_data_in <= '0;
         r_tag1      <= '0;
         r_tag2      <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         err_tag     <= 1'b0;
      end else begin
         mem_w_en <= w_accept & w_sel_we;
         mem_r_en <= w_accept & ~w_sel_we;
         if (w_accept) begin
            r_ptr <= w_ptr_next;
            if (w_sel_we) begin
               mem_w_adrs  <= w_sel_adrs;
               mem_data_in <= w_sel_wdata;
            end else begin
               mem_r_adrs  <= w_sel_adrs;
            end
         end
         r_tag1.valid <= w_accept & ~w_sel_we;
         r_tag1.owner <= OWNER_W'(w_idx);
         r_tag2       <= r_tag1;
         rsp_valid    <= w_rsp_ok ? w_owner_hot : '0;
         if (w_rsp_ok)
            rsp_data <= mem_data_out;
         if (w_err_set)
            err_tag <= 1'b1;
      end
   end

endmodule
